// File: rtl/prod_accum_unit_pkg.sv
// Shared types and constants for the product accumulator slice.
package prod_accum_pkg;

  localparam int unsigned PROD_W    = 8;
  localparam int unsigned ACC_W_DEF = 16;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [0:0] {
    ST_ACC,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/prod_accum_unit_if.sv
// Beat input / frame result handshake bundle for prod_accum_unit.
interface prod_accum_unit_if
  import prod_accum_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;

  modport slave (
    input  clr, in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_sat
  );

  modport master (
    output clr, in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_sat
  );

endinterface

// File: rtl/prod_accum_unit_sat_adder.sv
// Saturating adder: W-bit accumulator plus zero-extended product.
module sat_adder
  import prod_accum_pkg::*;
#(
  parameter int unsigned W = ACC_W_DEF
) (
  input  logic [W-1:0]      a,
  input  logic [PROD_W-1:0] b,
  output logic [W-1:0]      sum,
  output logic              ovf
);

  logic [W:0] w_full;

  assign w_full = {1'b0, a} + {{(W + 1 - PROD_W){1'b0}}, b};
  assign ovf    = w_full[W];
  // Clamp on carry-out; an all-ones input stays all-ones for any b.
  assign sum    = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule

// File: rtl/prod_accum_unit.sv
// Frame accumulator: sums product beats until last, then holds the result on a valid/ready port.
module prod_accum_unit
  import prod_accum_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  prod_accum_unit_if.slave  bus
);

  state_e           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_out_sat;

  logic [ACC_W-1:0] w_sum;
  logic             w_ovf;
  logic [CNT_W-1:0] w_cnt_inc;

  sat_adder #(
    .W (ACC_W)
  ) u_sat_adder (
    .a   (r_acc),
    .b   (bus.in_prod),
    .sum (w_sum),
    .ovf (w_ovf)
  );

  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  // State decode only, so no combinational path from in_valid.
  assign bus.in_ready  = (r_state == ST_ACC);
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_count = r_out_cnt;
  assign bus.out_sat   = r_out_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cnt   <= '0;
      r_out_sat   <= 1'b0;
    end else if (bus.clr) begin
      r_state     <= ST_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cnt   <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_ACC: begin
          if (bus.in_valid) begin
            if (bus.in_last) begin
              r_out_sum   <= w_sum;
              r_out_cnt   <= w_cnt_inc;
              r_out_sat   <= r_sat | w_ovf;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_sat       <= 1'b0;
              r_state     <= ST_HOLD;
            end else begin
              r_acc <= w_sum;
              r_cnt <= w_cnt_inc;
              r_sat <= r_sat | w_ovf;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_ACC;
          end
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum_unit.sv
// Scoreboard bench: three widths of prod_accum_unit driven by one beat stream and one model.
module tb_prod_accum_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_prod = 8'd0;
  logic       in_last = 1'b0;
  logic       ready_force = 1'b1;
  logic       rand_ready = 1'b0;
  logic       r_rnd = 1'b0;
  logic       out_ready;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int unsigned sum;
    int unsigned n;
  } frame_t;

  frame_t      sb[$];
  int unsigned m_sum = 0;
  int unsigned m_n = 0;

  always #5 clk = ~clk;

  assign out_ready = rand_ready ? r_rnd : ready_force;

  prod_accum_unit_if #(.ACC_W(16), .CNT_W(8)) bus_a ();
  prod_accum_unit_if #(.ACC_W(9),  .CNT_W(8)) bus_b ();
  prod_accum_unit_if #(.ACC_W(16), .CNT_W(2)) bus_c ();

  assign bus_a.clr = clr;       assign bus_b.clr = clr;       assign bus_c.clr = clr;
  assign bus_a.in_valid = in_valid;
  assign bus_b.in_valid = in_valid;
  assign bus_c.in_valid = in_valid;
  assign bus_a.in_prod = in_prod;
  assign bus_b.in_prod = in_prod;
  assign bus_c.in_prod = in_prod;
  assign bus_a.in_last = in_last;
  assign bus_b.in_last = in_last;
  assign bus_c.in_last = in_last;
  assign bus_a.out_ready = out_ready;
  assign bus_b.out_ready = out_ready;
  assign bus_c.out_ready = out_ready;

  prod_accum_unit #(.ACC_W(16), .CNT_W(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  prod_accum_unit #(.ACC_W(9),  .CNT_W(8)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  prod_accum_unit #(.ACC_W(16), .CNT_W(2)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  function automatic int unsigned lim(input int unsigned v, input int unsigned w);
    int unsigned m;
    m = (32'd1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs at each negedge: sees exactly what the next posedge will act on.
  task automatic monitor_step();
    frame_t e;
    if (!rst_n) return;
    if (clr) begin
      m_sum = 0;
      m_n   = 0;
      return;
    end
    if (in_valid && bus_a.in_ready) begin
      m_sum += in_prod;
      m_n++;
      if (in_last) begin
        sb.push_back('{sum: m_sum, n: m_n});
        m_sum = 0;
        m_n   = 0;
      end
    end
    if (bus_a.out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("a_sum",   bus_a.out_sum,   lim(e.sum, 16));
        check_val("a_count", bus_a.out_count, lim(e.n, 8));
        check_val("a_sat",   bus_a.out_sat,   32'(e.sum > 65535));
        check_val("b_valid", bus_b.out_valid, 32'd1);
        check_val("b_sum",   bus_b.out_sum,   lim(e.sum, 9));
        check_val("b_count", bus_b.out_count, lim(e.n, 8));
        check_val("b_sat",   bus_b.out_sat,   32'(e.sum > 511));
        check_val("c_valid", bus_c.out_valid, 32'd1);
        check_val("c_sum",   bus_c.out_sum,   lim(e.sum, 16));
        check_val("c_count", bus_c.out_count, lim(e.n, 2));
      end
    end
  endtask

  task automatic send_beat(input int unsigned p, input bit last);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_prod  = 8'(p);
    in_last  = last;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = bus_a.in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check_val("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_prod  = 8'($urandom_range(0, 255));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb.size() != 0 || bus_a.out_valid); i++) @(negedge clk);
    check_val("drain", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
      forever begin
        @(posedge clk);
        #1;
        r_rnd = 1'($urandom_range(0, 1));
      end
    join_none

    #3;
    check_val("rst_valid", bus_a.out_valid, 32'd0);
    check_val("rst_sum",   bus_a.out_sum,   32'd0);
    check_val("rst_count", bus_a.out_count, 32'd0);
    check_val("rst_sat",   bus_a.out_sat,   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", bus_a.in_ready, 32'd1);
    @(posedge clk);
    #1;

    // 3,5,7: result visible for exactly one cycle with out_ready high
    send_beat(3, 1'b0);
    send_beat(5, 1'b0);
    send_beat(7, 1'b1);
    @(negedge clk);
    check_val("t1_valid_hi", bus_a.out_valid, 32'd1);
    check_val("t1_sum",      bus_a.out_sum,   32'd15);
    @(negedge clk);
    check_val("t1_valid_lo", bus_a.out_valid, 32'd0);
    @(posedge clk);
    #1;

    // 9-bit saturation
    send_beat(225, 1'b0);
    send_beat(225, 1'b0);
    send_beat(225, 1'b1);
    drain();

    // Backpressure on a single-beat frame
    ready_force = 1'b0;
    send_beat(225, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("hold_valid", bus_a.out_valid, 32'd1);
      check_val("hold_ready", bus_a.in_ready,  32'd0);
      check_val("hold_sum",   bus_a.out_sum,   32'd225);
      check_val("hold_count", bus_a.out_count, 32'd1);
    end
    @(posedge clk);
    #1;
    ready_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("post_hs_ready", bus_a.in_ready,  32'd1);
    check_val("post_hs_valid", bus_a.out_valid, 32'd0);
    check_val("post_hs_sum",   bus_a.out_sum,   32'd225);
    @(posedge clk);
    #1;

    // clr coincident with the last beat discards the frame and the old result
    send_beat(10, 1'b0);
    send_beat(20, 1'b0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_prod  = 8'd30;
    in_last  = 1'b1;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check_val("clr_valid", bus_a.out_valid, 32'd0);
    check_val("clr_sum",   bus_a.out_sum,   32'd0);
    check_val("clr_count", bus_a.out_count, 32'd0);
    @(posedge clk);
    #1;
    send_beat(4, 1'b1);
    drain();

    // Count saturation on the 2-bit counter
    for (int i = 0; i < 5; i++) send_beat(1, i == 4);
    drain();

    // Long frame saturating both 16-bit sum and 8-bit count
    for (int i = 0; i < 300; i++) send_beat(255, i == 299);
    drain();

    // Random stream with input gaps and random output backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      int unsigned len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < int'(len); b++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send_beat($urandom_range(0, 255), b == int'(len) - 1);
      end
    end
    drain();
    rand_ready = 1'b0;

    check_val("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/prod_accum_unit.md
# prod_accum_unit

Stream accumulator that sits directly downstream of the 4x4 array multiplier and consumes its 8-bit unsigned products. It sums a frame of products (terminated by a last flag) into a saturating wide accumulator, counts the beats, and presents the frame result on a valid/ready output port. It turns the combinational multiplier into a dot-product / MAC datapath.

## Interface
- ACC_W, 16, accumulator and result width in bits (min 9)
- CNT_W, 8, beat-counter width in bits
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear; aborts the current frame
- in_valid  in  1  product beat valid
- in_ready  out  1  block can accept a beat
- in_prod  in  8  unsigned product from the multiplier
- in_last  in  1  beat is final of frame; qualified by in_valid
- out_valid  out  1  frame result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  ACC_W  frame sum, saturated
- out_count  out  CNT_W  beats in frame, saturated
- out_sat  out  1  sum saturated at some point in the frame

## Operation
- Two states: ACC (accepting beats) and HOLD (result presented).
- Reset (rst_n low): state ACC, accumulator 0, count 0, sticky sat 0, out_valid 0, out_sum 0, out_count 0, out_sat 0; in_ready is 1 once reset deasserts.
- ACC: in_ready=1, out_valid=0. A beat is accepted when in_valid && in_ready.
  - Non-last beat: acc <= sat_add(acc, in_prod); count <= count+1, saturating at 2^CNT_W-1; sat |= overflow.
  - Last beat: out_sum <= sat_add(acc, in_prod); out_count <= count+1 (saturating); out_sat <= sat | overflow; acc, count, sat cleared; go to HOLD.
- HOLD: in_ready=0, out_valid=1, and out_sum/out_count/out_sat stay stable. When out_valid && out_ready: out_valid <= 0 and go to ACC. out_sum, out_count and out_sat keep their last values after the handshake.
- Arithmetic: in_prod is zero-extended to ACC_W. On carry-out the sum clamps to all-ones and overflow=1. Once saturated, the sum stays at all-ones for the rest of the frame.
- A single-beat frame (in_last on the first beat) yields out_sum=in_prod, out_count=1.
- clr has priority over every other event in the same cycle: go to ACC, clear acc, count and sat, out_valid <= 0. Any beat presented in that cycle is discarded. out_sum, out_count and out_sat are cleared to 0.
- rst_n asserted mid-frame or during HOLD: immediate return to reset values; the partial frame is lost.
- in_valid may depend combinationally on in_ready. in_ready must not depend combinationally on in_valid. out_valid never depends on out_ready.

## Timing
- in_ready and out_valid are registered-state decodes, with no input-to-output combinational path.
- Latency: the last beat accepted at edge N sets out_valid=1 after edge N.
- Earliest next accept: the cycle after the output handshake. Minimum frame period = beats + 1 cycles when out_ready is held high.
- Throughput inside a frame: one beat per cycle.
- Upstream must hold in_prod and in_last stable while in_valid=1 and in_ready=0.

## Structure
- Package prod_accum_pkg: state enum (ST_ACC, ST_HOLD), default ACC_W/CNT_W constants, and the product width constant PROD_W=8.
- Sub-module sat_adder (parameter W): inputs a[W-1:0] and zero-extended b; outputs sum[W-1:0] and ovf. Purely combinational, instantiated once.
- Top holds the FSM, the acc/count/sat registers and the output registers.

## Test plan
- Reset, then frame 3,5,7 (last on 7) with out_ready=1 -> out_sum=15, out_count=3, out_sat=0; out_valid is high for exactly 1 cycle, the cycle after beat 7 is accepted.
- ACC_W=9: frame 225,225,225 -> out_sum=511, out_sat=1, out_count=3.
- Single beat 225 with last=1, out_ready=0 for 4 cycles -> out_valid held 4+ cycles, in_ready=0 throughout, outputs stable; then out_ready=1 -> handshake, in_ready=1 next cycle.
- Beats 10,20, then clr coincident with beat 30 (last) -> no result, count and acc cleared; next frame 4 (last) -> out_sum=4, out_count=1.
- Random in_valid gaps with a 1000-frame random product stream, compared against a reference model -> sums and counts match; no beat accepted while in_ready=0.
- CNT_W=2: 5-beat frame of 1s -> out_count=3 (saturated), out_sum=5.
